// File: rtl/u_rec_if.sv
// Host-side bundle for the u_rec UART receiver: serial input, received byte,
// status flags and the ready/ack handshake.
interface u_rec_if #(
    parameter int WORD_LEN = 8
);
    logic                uart_dataH;
    logic                rec_ackH;
    logic [WORD_LEN-1:0] rec_dataH;
    logic                rec_readyH;
    logic                frame_errH;
    logic                overrunH;
    logic                rec_busyH;

    // The receiver drives the received byte and status back to the host.
    modport master (
        input  uart_dataH,
        input  rec_ackH,
        output rec_dataH,
        output rec_readyH,
        output frame_errH,
        output overrunH,
        output rec_busyH
    );

    modport slave (
        output uart_dataH,
        output rec_ackH,
        input  rec_dataH,
        input  rec_readyH,
        input  frame_errH,
        input  overrunH,
        input  rec_busyH
    );
endinterface

// File: rtl/u_rec.sv
// UART 8N1 receive engine, sys_clk = 16x baud, ready/ack host handshake.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three line samples.
module u_rec #(
    parameter int WORD_LEN = 8,
    parameter int MID_CNT  = 7
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    u_rec_if.master  bus
);
    localparam int BW = $clog2(WORD_LEN + 1);

    typedef enum logic [2:0] {
        r_IDLE,
        r_START,
        r_DATA,
        r_STOP,
        r_BREAK
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [BW-1:0]       bits_q;
    logic [BW-1:0]       bits_d;
    logic [WORD_LEN-1:0] shift_q;
    logic [WORD_LEN-1:0] shift_d;
    logic [WORD_LEN-1:0] data_q;
    logic                sync1_q;
    logic                line_q;
    logic                ready_q;
    logic                ferr_q;
    logic                ovr_q;
    logic                busy_q;
    logic                sample;

    // Two-flop synchroniser; idle level is high so reset to 1.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sync1_q <= bus.uart_dataH;
            line_q  <= sync1_q;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], line_q};
        end
    end

    assign sample = (line_q & hist_q[0]) | (line_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = line_q;
`endif

    assign shift_d = {sample, shift_q[WORD_LEN-1:1]};
    assign bits_d  = bits_q + BW'(1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= r_IDLE;
            cnt_q   <= 4'd0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
            // An ack clears the flags unless a completion below overrides it.
            if (bus.rec_ackH) begin
                ready_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            case (state_q)
                r_IDLE: begin
                    cnt_q <= 4'd0;
                    if (!line_q) begin
                        state_q <= r_START;
                        busy_q  <= 1'b1;
                    end
                end
                r_START: begin
                    if (cnt_q == 4'(MID_CNT)) begin
                        cnt_q <= 4'd0;
                        if (sample) begin
                            state_q <= r_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= r_DATA;
                            bits_q  <= '0;
                        end
                    end
                end
                r_DATA: begin
                    if (cnt_q == 4'd15) begin
                        shift_q <= shift_d;
                        bits_q  <= bits_d;
                        if (bits_d == BW'(WORD_LEN)) begin
                            state_q <= r_STOP;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                r_STOP: begin
                    if (cnt_q == 4'd15) begin
                        cnt_q <= 4'd0;
                        if (sample) begin
                            data_q  <= shift_q;
                            ready_q <= 1'b1;
                            ferr_q  <= 1'b0;
                            ovr_q   <= ready_q & ~bus.rec_ackH;
                            state_q <= r_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= r_BREAK;
                        end
                    end
                end
                r_BREAK: begin
                    cnt_q <= 4'd0;
                    if (line_q) begin
                        state_q <= r_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= r_IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rec_dataH  = data_q;
    assign bus.rec_readyH = ready_q;
    assign bus.frame_errH = ferr_q;
    assign bus.overrunH   = ovr_q;
    assign bus.rec_busyH  = busy_q;
endmodule

// File: tb/tb_u_rec.sv
// Bench for u_rec: frame-level reference model driven by scheduled completion
// events, per-cycle output compare, directed cases plus random frames.
module tb_u_rec;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    u_rec_if #(.WORD_LEN(8)) rx_if ();

    u_rec #(.WORD_LEN(8), .MID_CNT(7)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (rx_if.master)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 1'b0;

    // Reference state: what the outputs must be after each edge.
    logic [7:0] m_data  = 8'h00;
    bit         m_ready = 1'b0;
    bit         m_ferr  = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_busy  = 1'b0;

    // Scheduled events keyed by posedge number: 1 = good stop, 2 = bad stop.
    int         ev_kind[int];
    logic [7:0] ev_data[int];
    bit         busy_on[int];
    bit         busy_off[int];

    int rise_cyc   = -1;
    int fall_cyc   = -1;
    bit prev_ready = 1'b0;
    bit prev_busy  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: applies the frame completion / handshake rules edge by edge.
    always @(posedge sys_clk) begin
        int c;
        c = cyc + 1;
        cyc <= c;
        if (sys_rst) begin
            m_data  <= 8'h00;
            m_ready <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            if (ev_kind.exists(c) && ev_kind[c] == 1) begin
                m_data  <= ev_data[c];
                m_ready <= 1'b1;
                m_ferr  <= 1'b0;
                m_ovr   <= m_ready && !rx_if.rec_ackH;
            end else begin
                if (ev_kind.exists(c)) m_ferr <= 1'b1;
                if (rx_if.rec_ackH) begin
                    m_ready <= 1'b0;
                    m_ovr   <= 1'b0;
                end
            end
            if (busy_on.exists(c))  m_busy <= 1'b1;
            if (busy_off.exists(c)) m_busy <= 1'b0;
        end
    end

    always @(negedge sys_clk) begin
        if (checking && !sys_rst) begin
            chk("rec_dataH",  rx_if.rec_dataH,  m_data);
            chk("rec_readyH", rx_if.rec_readyH, m_ready);
            chk("frame_errH", rx_if.frame_errH, m_ferr);
            chk("overrunH",   rx_if.overrunH,   m_ovr);
            chk("rec_busyH",  rx_if.rec_busyH,  m_busy);
            if (rx_if.rec_readyH && !prev_ready) rise_cyc = cyc;
            if (!rx_if.rec_busyH && prev_busy)   fall_cyc = cyc;
            prev_ready = rx_if.rec_readyH;
            prev_busy  = rx_if.rec_busyH;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            rx_if.uart_dataH = 1'b1;
            rx_if.rec_ackH   = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        @(negedge sys_clk);
        rx_if.uart_dataH = 1'b1;
        rx_if.rec_ackH   = 1'b1;
        @(negedge sys_clk);
        rx_if.rec_ackH   = 1'b0;
    endtask

    // Drives one 160-clock frame; s is the first edge that samples the start bit.
    task automatic send_frame(input logic [7:0] d, input bit stopv, input bit ack_done,
                              input bit rand_ack, input int glitch_k, input int abort_k,
                              output int s);
        logic b;
        @(negedge sys_clk);
        s = cyc + 1;
        busy_on[s+2] = 1'b1;
        if (stopv) begin
            ev_kind[s+154]  = 1;
            ev_data[s+154]  = d;
            busy_off[s+154] = 1'b1;
        end else begin
            ev_kind[s+154] = 2;
        end
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == abort_k) begin
                rx_if.uart_dataH = 1'b1;
                rx_if.rec_ackH   = 1'b0;
                sys_rst          = 1'b1;
                ev_kind.delete();
                ev_data.delete();
                busy_on.delete();
                busy_off.delete();
                return;
            end
            if (k < 16)       b = 1'b0;
            else if (k < 144) b = d[(k-16)/16];
            else              b = stopv;
            if (k == glitch_k) b = ~b;
            rx_if.uart_dataH = b;
            rx_if.rec_ackH   = ack_done ? (cyc == s + 153)
                                        : (rand_ack && $urandom_range(0, 31) == 0);
        end
    endtask

    task automatic release_break();
        int r;
        @(negedge sys_clk);
        r = cyc + 1;
        busy_off[r+2]    = 1'b1;
        rx_if.uart_dataH = 1'b1;
        rx_if.rec_ackH   = 1'b0;
    endtask

    task automatic glitch_pulse(output int s);
        @(negedge sys_clk);
        s = cyc + 1;
        busy_on[s+2]   = 1'b1;
        busy_off[s+10] = 1'b1;
        rx_if.uart_dataH = 1'b0;
        rx_if.rec_ackH   = 1'b0;
        repeat (3) @(negedge sys_clk);
        @(negedge sys_clk);
        rx_if.uart_dataH = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        int kind;
        rx_if.uart_dataH = 1'b1;
        rx_if.rec_ackH   = 1'b0;
        sys_rst          = 1'b1;
        #1;
        chk("reset_data",  rx_if.rec_dataH,  8'h00);
        chk("reset_ready", rx_if.rec_readyH, 1'b0);
        chk("reset_ferr",  rx_if.frame_errH, 1'b0);
        chk("reset_ovr",   rx_if.overrunH,   1'b0);
        chk("reset_busy",  rx_if.rec_busyH,  1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst  = 1'b0;
        checking = 1'b1;
        idle(5);

        // Single byte and its latency.
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, -1, s);
        chk("a5_latency", rise_cyc - s, 154);
        chk("a5_data",  rx_if.rec_dataH,  8'hA5);
        chk("a5_ready", rx_if.rec_readyH, 1'b1);
        chk("a5_ferr",  rx_if.frame_errH, 1'b0);
        chk("a5_ovr",   rx_if.overrunH,   1'b0);
        idle(2);
        pulse_ack();
        chk("ack_clears_ready", rx_if.rec_readyH, 1'b0);

        // Short low pulse is rejected at the start check.
        fall_cyc = -1;
        glitch_pulse(s);
        idle(12);
        chk("glitch_busy_fall", fall_cyc - s, 10);
        chk("glitch_ready", rx_if.rec_readyH, 1'b0);

        // Framing error, break release, then a good byte.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, s);
        chk("ferr_set",   rx_if.frame_errH, 1'b1);
        chk("ferr_ready", rx_if.rec_readyH, 1'b0);
        chk("ferr_data",  rx_if.rec_dataH,  8'hA5);
        release_break();
        idle(4);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, -1, s);
        chk("ferr_clear", rx_if.frame_errH, 1'b0);
        chk("good_11",    rx_if.rec_dataH,  8'h11);
        pulse_ack();

        // Back-to-back overrun.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1, -1, s);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, -1, -1, s);
        chk("ovr_data", rx_if.rec_dataH, 8'hAA);
        chk("ovr_set",  rx_if.overrunH,  1'b1);
        pulse_ack();
        chk("ovr_ack_ready", rx_if.rec_readyH, 1'b0);
        chk("ovr_ack_ovr",   rx_if.overrunH,   1'b0);

        // Ack on the completion edge of a second byte.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, -1, s);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, -1, -1, s);
        chk("simul_ready", rx_if.rec_readyH, 1'b1);
        chk("simul_ovr",   rx_if.overrunH,   1'b0);
        chk("simul_data",  rx_if.rec_dataH,  8'hC3);

        // Reset during data bit 3.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, -1, 72, s);
        #1;
        chk("rst_mid_data",  rx_if.rec_dataH,  8'h00);
        chk("rst_mid_ready", rx_if.rec_readyH, 1'b0);
        chk("rst_mid_busy",  rx_if.rec_busyH,  1'b0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        idle(3);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, s);
        chk("after_rst_ff", rx_if.rec_dataH, 8'hFF);
        pulse_ack();

`ifdef RX_MAJORITY_VOTE_EN
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 56, -1, s);
        chk("vote_glitch_data", rx_if.rec_dataH, 8'h96);
        pulse_ack();
`endif

        // Random frames, gaps, acks, breaks and start glitches.
        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                send_frame(8'($urandom), 1'b0, 1'b0, 1'b1, -1, -1, s);
                release_break();
                idle($urandom_range(0, 4));
            end else if (kind == 1) begin
                glitch_pulse(s);
                idle(12 + $urandom_range(0, 4));
            end else begin
                send_frame(8'($urandom), 1'b1, 1'b0, 1'b1, -1, -1, s);
                idle($urandom_range(0, 6));
            end
            if ($urandom_range(0, 1) == 1) pulse_ack();
        end

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
